// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache between the fetch stage and the
// memory controller's instruction port.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   rdy_i         global ready; when low every register holds
//   if_enable_i   fetch request, held with a stable if_pc_i until if_valid_o
//   if_pc_i       fetch address (bits [1:0] ignored)
//   if_valid_o    one-cycle response pulse
//   if_inst_o     instruction for if_pc_i, meaningful while if_valid_o=1
//   clear_i       pipeline flush; suppresses the lookup in the same cycle
//   mem_enable_o  word read request to the memory controller
//   mem_addr_o    word address of the current fill request
//   mem_done_i    one-cycle pulse: mem_data_i holds the word for mem_addr_o
//   mem_data_i    returned word
module icache_direct #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned WORD_BITS  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rdy_i,
   input  logic        if_enable_i,
   input  logic [31:0] if_pc_i,
   output logic        if_valid_o,
   output logic [31:0] if_inst_o,
   input  logic        clear_i,
   output logic        mem_enable_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_done_i,
   input  logic [31:0] mem_data_i
);

   localparam int unsigned TagBits = 32 - INDEX_BITS - WORD_BITS - 2;
   localparam int unsigned Lines   = 1 << INDEX_BITS;
   localparam int unsigned Words   = 1 << WORD_BITS;
   localparam int unsigned IdxLo   = WORD_BITS + 2;
   localparam int unsigned TagLo   = INDEX_BITS + WORD_BITS + 2;

   typedef enum logic [0:0] {StIdle, StFill} state_e;

   state_e               state_q, state_d;
   logic [Lines-1:0]     valid_q, valid_d;
   logic [WORD_BITS-1:0] cnt_q, cnt_d;
   logic                 if_valid_q, if_valid_d;
   logic [31:0]          if_inst_q, if_inst_d;
   logic                 mem_enable_q, mem_enable_d;
   logic [31:0]          mem_addr_q, mem_addr_d;

   // Tag and data storage carry no reset; the valid bits guard them.
   logic [TagBits-1:0]   tag_q  [Lines];
   logic [31:0]          data_q [Lines][Words];

   logic [INDEX_BITS-1:0] req_idx;
   logic [WORD_BITS-1:0]  req_off;
   logic [TagBits-1:0]    req_tag;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TagBits-1:0]    fill_tag;
   logic                  hit;
   logic                  fill_we;
   logic                  install;
   logic                  unused_pc;

   assign req_idx   = if_pc_i[TagLo-1:IdxLo];
   assign req_off   = if_pc_i[IdxLo-1:2];
   assign req_tag   = if_pc_i[31:TagLo];
   assign unused_pc = ^if_pc_i[1:0];

   // The fill address stays inside one aligned line, so its upper bits name
   // the line being filled for the whole fill.
   assign fill_idx = mem_addr_q[TagLo-1:IdxLo];
   assign fill_tag = mem_addr_q[31:TagLo];

   assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      cnt_d        = cnt_q;
      if_valid_d   = if_valid_q;
      if_inst_d    = if_inst_q;
      mem_enable_d = mem_enable_q;
      mem_addr_d   = mem_addr_q;
      fill_we      = 1'b0;
      install      = 1'b0;
      if (rdy_i) begin
         if_valid_d = 1'b0;
         unique case (state_q)
            StIdle: begin
               // A response in flight blocks the lookup so a held request is
               // not answered twice.
               if (!if_valid_q && !clear_i && if_enable_i) begin
                  if (hit) begin
                     if_valid_d = 1'b1;
                     if_inst_d  = data_q[req_idx][req_off];
                  end else begin
                     state_d      = StFill;
                     mem_enable_d = 1'b1;
                     mem_addr_d   = {if_pc_i[31:IdxLo], {IdxLo{1'b0}}};
                     cnt_d        = '0;
                  end
               end
            end
            StFill: begin
               if (mem_done_i) begin
                  fill_we = 1'b1;
                  if (&cnt_q) begin
                     install           = 1'b1;
                     valid_d[fill_idx] = 1'b1;
                     mem_enable_d      = 1'b0;
                     state_d           = StIdle;
                  end else begin
                     cnt_d      = cnt_q + WORD_BITS'(1);
                     mem_addr_d = mem_addr_q + 32'd4;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         valid_q      <= '0;
         cnt_q        <= '0;
         if_valid_q   <= 1'b0;
         if_inst_q    <= '0;
         mem_enable_q <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         cnt_q        <= cnt_d;
         if_valid_q   <= if_valid_d;
         if_inst_q    <= if_inst_d;
         mem_enable_q <= mem_enable_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_we) begin
         data_q[fill_idx][cnt_q] <= mem_data_i;
      end
      if (install) begin
         tag_q[fill_idx] <= fill_tag;
      end
   end

   assign if_valid_o   = if_valid_q;
   assign if_inst_o    = if_inst_q;
   assign mem_enable_o = mem_enable_q;
   assign mem_addr_o   = mem_addr_q;

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: a fetch driver pushes the expected instruction of
// each request into a queue, a monitor pops and compares on every if_valid,
// and a memory responder answers fills with random latency.
module tb_icache_direct;

   logic        clk;
   logic        rst_n;
   logic        rdy;
   logic        if_enable;
   logic [31:0] if_pc;
   logic        if_valid;
   logic [31:0] if_inst;
   logic        clear;
   logic        mem_enable;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_data;

   icache_direct dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .rdy_i       (rdy),
      .if_enable_i (if_enable),
      .if_pc_i     (if_pc),
      .if_valid_o  (if_valid),
      .if_inst_o   (if_inst),
      .clear_i     (clear),
      .mem_enable_o(mem_enable),
      .mem_addr_o  (mem_addr),
      .mem_done_i  (mem_done),
      .mem_data_i  (mem_data)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned resp_cnt = 0;
   int unsigned resp_cyc = 0;
   int unsigned done_total = 0;
   int unsigned last_done_cyc = 0;

   logic [31:0] exq [$];
   logic [31:0] addr_log [$];
   logic [31:0] mem_ovr [logic [31:0]];
   logic [31:0] model_line [int unsigned];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

   // Memory image: a few fixed words, everything else a bijective hash.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (mem_ovr.exists(w)) return mem_ovr[w];
      return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic int unsigned line_idx(input logic [31:0] pc);
      return int'(pc[9:4]);
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int unsigned ix;
      ix = line_idx(pc);
      return model_line.exists(ix) && (model_line[ix] == {pc[31:4], 4'h0});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Response monitor.
   initial forever begin
      logic [31:0] e;
      @(negedge clk);
      if (if_valid === 1'b1) begin
         resp_cnt++;
         resp_cyc = cyc;
         total++;
         if (exq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp: got if_valid=1 inst=%h, required no response", if_inst);
         end else begin
            e = exq.pop_front();
            if (if_inst !== e) begin
               bad++;
               $display("FAIL resp_inst: got %h required %h", if_inst, e);
            end
         end
      end
   end

   // Memory responder; sees rdy for the current cycle since it runs after the driver.
   initial begin
      int dly;
      dly = 0;
      mem_done = 1'b0;
      mem_data = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_done = 1'b0;
         mem_data = $urandom;
         if (rst_n === 1'b1 && rdy === 1'b1 && mem_enable === 1'b1) begin
            if (dly == 0) begin
               mem_done = 1'b1;
               mem_data = mem_word(mem_addr);
               done_total++;
               last_done_cyc = cyc;
               addr_log.push_back(mem_addr);
               dly = $urandom_range(0, 2);
            end else begin
               dly--;
            end
         end
      end
   end

   task automatic wait_dones(input int unsigned tgt);
      int unsigned n;
      n = 0;
      while (done_total < tgt && n < 200) begin
         @(posedge clk);
         #3;
         n++;
      end
      chk("wait_dones", 32'(done_total >= tgt), 32'd1);
   endtask

   // Issue one request (entered 1 time unit after a rising edge) and hold it
   // until the response is seen.
   task automatic fetch(input logic [31:0] pc);
      logic [31:0] base;
      bit          exp_hit;
      bit          seen_mem;
      int unsigned s, d0, rc0, n;
      base    = {pc[31:4], 4'h0};
      exp_hit = model_hit(pc);
      exq.push_back(mem_word(pc));
      d0  = done_total;
      rc0 = resp_cnt;
      addr_log.delete();
      if_enable = 1'b1;
      if_pc     = pc;
      s         = cyc;
      seen_mem  = 1'b0;
      n         = 0;
      while (resp_cnt == rc0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         if (mem_enable === 1'b1) seen_mem = 1'b1;
      end
      if_enable = 1'b0;
      if (resp_cnt == rc0) begin
         void'(exq.pop_back());
         bad++;
         total++;
         $display("FAIL resp_timeout: got no if_valid for pc %h, required a response", pc);
      end else begin
         chk("hit_vs_miss", 32'(!seen_mem), 32'(exp_hit));
         if (exp_hit) begin
            chk("hit_latency", resp_cyc - s, 32'd1);
            chk("hit_words", done_total - d0, 32'd0);
         end else begin
            chk("fill_words", done_total - d0, 32'd4);
            chk("miss_latency", resp_cyc, last_done_cyc + 2);
            if (addr_log.size() == 4) begin
               for (int k = 0; k < 4; k++) begin
                  chk("fill_addr", addr_log[k], base + 32'(4 * k));
               end
            end
         end
      end
      model_line[line_idx(pc)] = base;
   endtask

   task automatic stall_during_fill(input int unsigned d0);
      logic [31:0] hold_addr;
      wait_dones(d0 + 1);
      @(posedge clk);
      #1;
      rdy = 1'b0;
      hold_addr = mem_addr;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_addr", mem_addr, hold_addr);
         chk("stall_valid", 32'(if_valid), 32'd0);
         chk("stall_enable", 32'(mem_enable), 32'd1);
      end
      @(posedge clk);
      #1;
      rdy = 1'b1;
   endtask

   initial begin
      int unsigned d0;
      int unsigned n;
      logic [21:0] tg;
      logic [31:0] pc;
      rst_n = 1'b1;
      rdy = 1'b1;
      if_enable = 1'b0;
      if_pc = '0;
      clear = 1'b0;
      mem_ovr[32'h0] = 32'h11;
      mem_ovr[32'h4] = 32'h22;
      mem_ovr[32'h8] = 32'h33;
      mem_ovr[32'hC] = 32'h44;
      #1 rst_n = 1'b0;

      @(negedge clk);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      chk("rst_mem_enable", 32'(mem_enable), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Cold miss, hit, conflict eviction.
      fetch(32'h0000_0004);
      fetch(32'h0000_000C);
      fetch(32'h0000_0400);
      fetch(32'h0000_0000);

      // Clear in the same cycle as a hit.
      if_enable = 1'b1;
      if_pc = 32'h8;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      if_enable = 1'b0;
      chk("clear_hit_valid", 32'(if_valid), 32'd0);
      chk("clear_hit_mem", 32'(mem_enable), 32'd0);
      @(posedge clk);
      #1;
      fetch(32'h0000_0008);

      // Clear mid-fill: the line is still installed.
      d0 = done_total;
      if_enable = 1'b1;
      if_pc = 32'h0000_1230;
      wait_dones(d0 + 1);
      @(posedge clk);
      #1;
      clear = 1'b1;
      if_enable = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      n = 0;
      while (mem_enable === 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("clear_fill_words", done_total - d0, 32'd4);
      model_line[line_idx(32'h1230)] = 32'h1230;
      repeat (3) @(posedge clk);
      #1;
      fetch(32'h0000_1238);

      // Reset after two of four words.
      d0 = done_total;
      if_enable = 1'b1;
      if_pc = 32'h0000_2000;
      wait_dones(d0 + 2);
      @(posedge clk);
      #4;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_enable", 32'(mem_enable), 32'd0);
      chk("midrst_mem_addr", mem_addr, 32'd0);
      chk("midrst_if_valid", 32'(if_valid), 32'd0);
      if_enable = 1'b0;
      model_line.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fetch(32'h0000_2004);

      // rdy stall during a fill.
      d0 = done_total;
      fork
         fetch(32'h0000_3010);
         stall_during_fill(d0);
      join

      // Random requests over a few indices and three tags, incl. the top of memory.
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 2))
            0:       tg = 22'h0;
            1:       tg = 22'h1;
            default: tg = 22'h3F_FFFF;
         endcase
         pc = {tg, 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         fetch(pc);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (6) @(posedge clk);
      #1;
      chk("drain_queue", 32'(exq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
